// File: rtl/output_fetch_cdf_lanes.sv
// output_fetch_cdf_lanes
// Selects one CDF lane from a packed read-bus word, or serialises a run of
// lanes from a captured copy of the word. Output is a registered
// valid/ready beat stream with lane index and last-beat flag.
module output_fetch_cdf_lanes #(
  parameter int BUS_W  = 128,
  parameter int DATA_W = 20,
  parameter int LANES  = 6,
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BUS_W-1:0]  read_bus,
  input  logic              start_in,
  input  logic [SEL_W-1:0]  lane_sel,
  input  logic              burst,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              start_out,
  output logic [SEL_W-1:0]  lane_out,
  output logic              last_out,
  input  logic              out_ready,
  output logic              busy
);

  // Lane selects are padded up to a power of two so any lane_sel value
  // indexes a defined slot; slots beyond LANES read as zero.
  localparam int NSLOT = 2 ** SEL_W;
  localparam int WORD_W = LANES * DATA_W;
  localparam logic [SEL_W:0]   LANES_EXT = (SEL_W + 1)'(LANES);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] ONE_SEL   = SEL_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [SEL_W-1:0]    lane_q,  lane_d;
  logic                last_q,  last_d;
  logic [WORD_W-1:0]   word_q,  word_d;

  logic [DATA_W-1:0]   bus_lane_s  [NSLOT];
  logic [DATA_W-1:0]   word_lane_s [NSLOT];
  logic                lane_valid_s;
  logic                accept_s;
  logic                consume_s;
  logic [SEL_W-1:0]    next_lane_s;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < LANES) begin : g_real
      assign bus_lane_s[g]  = read_bus[g*DATA_W +: DATA_W];
      assign word_lane_s[g] = word_q[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign bus_lane_s[g]  = '0;
      assign word_lane_s[g] = '0;
    end
  end

  assign lane_valid_s = ({1'b0, lane_sel} < LANES_EXT);
  assign in_ready     = (state_q == ST_IDLE) & (~start_q | out_ready);
  assign accept_s     = start_in & in_ready;
  assign consume_s    = start_q & out_ready;
  assign next_lane_s  = lane_q + ONE_SEL;

  assign start_out = start_q;
  assign data_out  = data_q;
  assign lane_out  = lane_q;
  assign last_out  = last_q;
  assign busy      = (state_q == ST_SERIAL);

  // Next-state: accept a request, advance a burst, or retire/hold the beat.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    data_d  = data_q;
    lane_d  = lane_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          start_d = 1'b1;
          lane_d  = lane_sel;
          if (!lane_valid_s) begin
            // Out-of-range lane: a single zero beat, never a burst.
            data_d = '0;
            last_d = 1'b1;
          end else begin
            data_d = bus_lane_s[lane_sel];
            if (burst) begin
              word_d = read_bus[WORD_W-1:0];
            end else begin
              word_d = word_q;
            end
            if (burst && (lane_sel != LAST_LANE)) begin
              last_d  = 1'b0;
              state_d = ST_SERIAL;
            end else begin
              last_d = 1'b1;
            end
          end
        end else if (consume_s) begin
          start_d = 1'b0;
        end else begin
          start_d = start_q;
        end
      end
      ST_SERIAL: begin
        // A beat is always pending here; each hand-off loads the next lane.
        if (consume_s) begin
          start_d = 1'b1;
          lane_d  = next_lane_s;
          data_d  = word_lane_s[next_lane_s];
          last_d  = (next_lane_s == LAST_LANE);
          if (next_lane_s == LAST_LANE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SERIAL;
          end
        end else begin
          state_d = ST_SERIAL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // State, output and word-buffer registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_output_fetch_cdf_lanes.sv
// Directed and random stimulus for output_fetch_cdf_lanes, checked against
// a queue of expected beats built from the lane/burst rules.
module tb_output_fetch_cdf_lanes;

  localparam int BUS_W  = 128;
  localparam int DATA_W = 20;
  localparam int LANES  = 6;
  localparam int SEL_W  = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [BUS_W-1:0]  read_bus;
  logic              start_in;
  logic [SEL_W-1:0]  lane_sel;
  logic              burst;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              start_out;
  logic [SEL_W-1:0]  lane_out;
  logic              last_out;
  logic              out_ready;
  logic              busy;

  always #5 clock = ~clock;

  output_fetch_cdf_lanes #(.BUS_W(BUS_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
    .clock(clock), .reset_n(reset_n), .read_bus(read_bus), .start_in(start_in),
    .lane_sel(lane_sel), .burst(burst), .in_ready(in_ready), .data_out(data_out),
    .start_out(start_out), .lane_out(lane_out), .last_out(last_out),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  lane;
    logic              last;
  } beat_t;

  beat_t q[$];   // front = beat currently presented
  beat_t held;   // last beat retired (values held when idle)
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane_of(input logic [BUS_W-1:0] bus, input int k);
    logic [BUS_W-1:0] t;
    t = bus >> (k * DATA_W);
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [BUS_W-1:0] rnd_bus();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one cycle of inputs, check outputs, then advance the model.
  task automatic step(input logic s, input logic [SEL_W-1:0] sel, input logic b,
                      input logic ordy, input logic [BUS_W-1:0] bus);
    beat_t cur;
    logic  exp_ir;
    logic  acc;
    start_in = s; lane_sel = sel; burst = b; out_ready = ordy; read_bus = bus;
    #1;
    if (q.size() != 0) cur = q[0];
    else cur = held;
    // Ready only when no further burst beats are queued behind the current one.
    exp_ir = (q.size() <= 1) && ((q.size() == 0) || ordy);
    chk("start_out", 32'(start_out), 32'(q.size() != 0));
    chk("data_out",  32'(data_out),  32'(cur.data));
    chk("lane_out",  32'(lane_out),  32'(cur.lane));
    chk("last_out",  32'(last_out),  32'(cur.last));
    chk("in_ready",  32'(in_ready),  32'(exp_ir));
    chk("busy",      32'(busy),      32'(q.size() > 1));
    acc = s & exp_ir;
    @(posedge clock);
    if ((q.size() != 0) && ordy) begin
      held = q[0];
      q.delete(0);
    end
    if (acc) begin
      if (int'(sel) >= LANES) begin
        q.push_back('{'0, sel, 1'b1});
      end else if (b) begin
        for (int k = int'(sel); k < LANES; k++)
          q.push_back('{lane_of(bus, k), SEL_W'(k), (k == LANES - 1)});
      end else begin
        q.push_back('{lane_of(bus, int'(sel)), sel, 1'b1});
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [BUS_W-1:0] bus;
    reset_n = 1'b0; start_in = 1'b0; lane_sel = '0; burst = 1'b0;
    out_ready = 1'b0; read_bus = '0;
    held = '{'0, '0, 1'b0};
    #3;
    chk("rst_start", 32'(start_out), 32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Single lane 0, then the beat retires and data holds.
    bus = rnd_bus(); bus[19:0] = 20'hABCDE;
    step(1'b1, 3'd0, 1'b0, 1'b1, bus);
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Single lane 3 held under back-pressure; requests meanwhile are dropped.
    bus = rnd_bus(); bus[79:60] = 20'h12345;
    step(1'b1, 3'd3, 1'b0, 1'b1, bus);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 1'b0, 1'b0, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Burst from lane 2 with a stall; bus scrambled after accept.
    bus = rnd_bus();
    for (int k = 2; k < LANES; k++) bus[k*DATA_W +: DATA_W] = 20'(k);
    step(1'b1, 3'd2, 1'b1, 1'b1, bus);
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b1, 3'd0, 1'b0, 1'b0, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Out-of-range lane with burst set, and a burst starting at the last lane.
    step(1'b1, 3'd7, 1'b1, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b1, 3'd5, 1'b1, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Back-to-back singles, one beat per cycle.
    step(1'b1, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b1, 3'd1, 1'b0, 1'b1, rnd_bus());
    step(1'b1, 3'd2, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
           ($urandom % 4) != 0, rnd_bus());
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    // Reset asserted while burst lane 3 is on the output.
    step(1'b1, 3'd0, 1'b1, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());
    chk("pre_rst_lane", 32'(lane_out), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_start", 32'(start_out), 32'd0);
    chk("arst_data",  32'(data_out),  32'd0);
    chk("arst_lane",  32'(lane_out),  32'd0);
    chk("arst_last",  32'(last_out),  32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    q.delete();
    held = '{'0, '0, 1'b0};
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b0, 1'b1, rnd_bus());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
